// File: rtl/mealy_table_engine.sv
// Table-driven Mealy control automaton: {state, x} indexes a loadable table
// giving the next state and micro-operation strobes, wrapped in IDLE/RUN/ERR run control.
module mealy_table_engine #(
   parameter int SW = 4,
   parameter int NI = 2,
   parameter int NO = 9,
   parameter int NS = 10,
   parameter int CW = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic [NI-1:0]    x,
   input  logic             start,
   input  logic             en,
   input  logic             stop,
   input  logic             cfg_we,
   input  logic [SW+NI-1:0] cfg_addr,
   input  logic [SW+NO:0]   cfg_data,
   output logic [NO-1:0]    t,
   output logic [SW-1:0]    state,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             cfg_rej,
   output logic [CW-1:0]    cycles
);

   localparam int AW = SW + NI;
   localparam int DEPTH = 1 << AW;
   localparam logic [SW:0] NS_W = (SW+1)'(NS);

   typedef enum logic [1:0] {CTRL_IDLE, CTRL_RUN, CTRL_ERR} ctrl_e;

   ctrl_e            ctrl_q, ctrl_d;
   logic [SW-1:0]    state_q, state_d;
   logic             done_q, done_d;
   logic             rej_q, rej_d;
   logic [CW-1:0]    cycles_q, cycles_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [SW+NO-1:0] body_q [DEPTH];

   logic [AW-1:0]    idx;
   logic             e_valid;
   logic [SW-1:0]    e_next;
   logic [NO-1:0]    e_out;
   logic             state_legal;
   logic             cfg_ok;

   assign idx         = {state_q, x};
   assign e_valid     = valid_q[idx];
   assign e_next      = body_q[idx][SW+NO-1:NO];
   assign e_out       = body_q[idx][NO-1:0];
   assign state_legal = {1'b0, state_q} < NS_W;
   assign cfg_ok      = cfg_we && (ctrl_q != CTRL_RUN);

   always_comb begin
      ctrl_d   = ctrl_q;
      state_d  = state_q;
      done_d   = 1'b0;
      rej_d    = cfg_we && (ctrl_q == CTRL_RUN);
      cycles_d = cycles_q;
      valid_d  = valid_q;
      t        = '0;
      if (cfg_ok) valid_d[cfg_addr] = cfg_data[SW+NO];
      case (ctrl_q)
         CTRL_IDLE: begin
            state_d = '0;
            if (start && !stop) ctrl_d = CTRL_RUN;
         end
         CTRL_RUN: begin
            if (stop) begin
               ctrl_d  = CTRL_IDLE;
               state_d = '0;
            end else if (en) begin
               if (e_valid && state_legal) begin
                  t       = e_out;
                  state_d = e_next;
                  // Returning to state 0 from elsewhere closes one controller cycle.
                  if (e_next == '0 && state_q != '0) begin
                     done_d = 1'b1;
                     if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
                  end
               end else begin
                  ctrl_d = CTRL_ERR;
               end
            end
         end
         CTRL_ERR: begin
            if (stop) begin
               ctrl_d  = CTRL_IDLE;
               state_d = '0;
            end
         end
         default: begin
            ctrl_d  = CTRL_IDLE;
            state_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         ctrl_q   <= CTRL_IDLE;
         state_q  <= '0;
         done_q   <= 1'b0;
         rej_q    <= 1'b0;
         cycles_q <= '0;
         valid_q  <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         state_q  <= state_d;
         done_q   <= done_d;
         rej_q    <= rej_d;
         cycles_q <= cycles_d;
         valid_q  <= valid_d;
      end
   end

   // Entry payload is qualified by its valid bit, so it carries no reset.
   always_ff @(posedge clk) begin
      if (cfg_ok) body_q[cfg_addr] <= cfg_data[SW+NO-1:0];
   end

   assign state   = state_q;
   assign busy    = (ctrl_q == CTRL_RUN);
   assign err     = (ctrl_q == CTRL_ERR);
   assign done    = done_q;
   assign cfg_rej = rej_q;
   assign cycles  = cycles_q;

endmodule

// File: tb/tb_mealy_table_engine.sv
// Self-checking bench for mealy_table_engine: directed scenarios plus random
// stimulus, checked every cycle against a table/mode model (two counter widths).
module tb_mealy_table_engine;

   localparam int SW = 4;
   localparam int NI = 2;
   localparam int NO = 9;
   localparam int NS = 10;
   localparam int M_IDLE = 0;
   localparam int M_RUN = 1;
   localparam int M_ERR = 2;

   logic             clk = 1'b0;
   logic             res;
   logic [NI-1:0]    x;
   logic             start, en, stop, cfg_we;
   logic [SW+NI-1:0] cfg_addr;
   logic [SW+NO:0]   cfg_data;

   logic [NO-1:0] t_a, t_b;
   logic [SW-1:0] state_a, state_b;
   logic          busy_a, busy_b, done_a, done_b, err_a, err_b, rej_a, rej_b;
   logic [7:0]    cycles_a;
   logic [1:0]    cycles_b;

   int n_cmp = 0;
   int n_fail = 0;

   mealy_table_engine #(.SW(SW), .NI(NI), .NO(NO), .NS(NS), .CW(8)) u_dut (
      .clk(clk), .res(res), .x(x), .start(start), .en(en), .stop(stop),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .t(t_a), .state(state_a), .busy(busy_a), .done(done_a), .err(err_a),
      .cfg_rej(rej_a), .cycles(cycles_a)
   );

   mealy_table_engine #(.SW(SW), .NI(NI), .NO(NO), .NS(NS), .CW(2)) u_sat (
      .clk(clk), .res(res), .x(x), .start(start), .en(en), .stop(stop),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .t(t_b), .state(state_b), .busy(busy_b), .done(done_b), .err(err_b),
      .cfg_rej(rej_b), .cycles(cycles_b)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, act=running req=finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   bit m_valid [64];
   int m_next  [64];
   int m_out   [64];
   int m_mode = M_IDLE;
   int m_state = 0;
   int m_cyc8 = 0;
   int m_cyc2 = 0;
   bit m_done = 0;
   bit m_rej = 0;

   function automatic int exp_t();
      int i;
      i = m_state * 4 + int'(x);
      if (m_mode == M_RUN && en && !stop && m_valid[i] && m_state < NS) return m_out[i];
      return 0;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge res);
         if (res) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_mode = M_IDLE; m_state = 0; m_cyc8 = 0; m_cyc2 = 0;
            m_done = 0; m_rej = 0;
         end else begin
            int i;
            i = m_state * 4 + int'(x);
            m_done = 0;
            m_rej = 0;
            if (cfg_we) begin
               if (m_mode == M_RUN) m_rej = 1;
               else begin
                  m_valid[cfg_addr] = cfg_data[SW+NO];
                  m_next[cfg_addr]  = int'(cfg_data[SW+NO-1:NO]);
                  m_out[cfg_addr]   = int'(cfg_data[NO-1:0]);
               end
            end
            if (m_mode == M_IDLE) begin
               m_state = 0;
               if (start && !stop) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
               if (stop) begin
                  m_mode = M_IDLE; m_state = 0;
               end else if (en) begin
                  if (m_valid[i] && m_state < NS) begin
                     if (m_next[i] == 0 && m_state != 0) begin
                        m_done = 1;
                        m_cyc8 = (m_cyc8 < 255) ? m_cyc8 + 1 : 255;
                        m_cyc2 = (m_cyc2 < 3) ? m_cyc2 + 1 : 3;
                     end
                     m_state = m_next[i];
                  end else begin
                     m_mode = M_ERR;
                  end
               end
            end else begin
               if (stop) begin
                  m_mode = M_IDLE; m_state = 0;
               end
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check("t",        32'(t_a),      32'(exp_t()));
         check("state",    32'(state_a),  32'(m_state));
         check("busy",     32'(busy_a),   32'(m_mode == M_RUN));
         check("err",      32'(err_a),    32'(m_mode == M_ERR));
         check("done",     32'(done_a),   32'(m_done));
         check("cfg_rej",  32'(rej_a),    32'(m_rej));
         check("cycles",   32'(cycles_a), 32'(m_cyc8));
         check("t_sat",    32'(t_b),      32'(exp_t()));
         check("state_sat",32'(state_b),  32'(m_state));
         check("done_sat", 32'(done_b),   32'(m_done));
         check("cyc_sat",  32'(cycles_b), 32'(m_cyc2));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      x = '0; start = 0; en = 0; stop = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
   endtask

   task automatic do_reset();
      res = 1;
      idle_inputs();
      tick();
      tick();
      res = 0;
   endtask

   task automatic cfg_write(input int st, input int xx, input bit v, input int nx, input int o);
      cfg_we   = 1;
      cfg_addr = (SW+NI)'(st * 4 + xx);
      cfg_data = {v, SW'(nx), NO'(o)};
      tick();
      cfg_we   = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      check("rst_state", 32'(state_a), 0);
      check("rst_busy",  32'(busy_a), 0);
      check("rst_cyc",   32'(cycles_a), 0);

      // two-state loop, self-loop entry for the Mealy test
      cfg_write(0, 1, 1, 1, 'h002);
      cfg_write(1, 1, 1, 0, 'h100);
      cfg_write(0, 0, 1, 0, 'h001);
      start = 1;
      tick();
      start = 0; en = 1; x = 2'b01;
      #1;
      check("loop_t0", 32'(t_a), 'h002);
      tick();
      check("loop_s1", 32'(state_a), 1);
      check("loop_t1", 32'(t_a), 'h100);
      tick();
      check("loop_s0", 32'(state_a), 0);
      check("loop_done", 32'(done_a), 1);
      repeat (4) tick();
      check("loop_cyc3", 32'(cycles_a), 3);
      repeat (4) tick();
      check("cyc5", 32'(cycles_a), 5);
      check("cyc_sat3", 32'(cycles_b), 3);
      check("sat_done", 32'(done_b), 1);

      // Mealy zero latency and 0->0 self-loop
      #2 x = 2'b00;
      #1;
      check("mealy_t", 32'(t_a), 'h001);
      tick();
      check("selfloop_done", 32'(done_a), 0);
      check("selfloop_s", 32'(state_a), 0);
      x = 2'b01;
      tick();
      en = 0;
      #1;
      check("en0_t", 32'(t_a), 0);
      // write during RUN must be rejected
      cfg_we = 1; cfg_addr = 6'h05; cfg_data = {1'b1, 4'd0, 9'h0AA};
      tick();
      cfg_we = 0;
      check("en0_hold", 32'(state_a), 1);
      check("rej_pulse", 32'(rej_a), 1);
      en = 1;
      #1;
      check("rej_table", 32'(t_a), 'h100);
      tick();
      check("rej_clear", 32'(rej_a), 0);

      // asynchronous reset mid-run
      #2 res = 1;
      #1;
      check("ares_t", 32'(t_a), 0);
      check("ares_state", 32'(state_a), 0);
      check("ares_busy", 32'(busy_a), 0);
      check("ares_err", 32'(err_a), 0);
      check("ares_cyc", 32'(cycles_a), 0);
      tick();
      res = 0;
      idle_inputs();
      start = 1;
      tick();
      start = 0; en = 1; x = 2'b01;
      #1;
      check("empty_t", 32'(t_a), 0);
      tick();
      check("empty_err", 32'(err_a), 1);
      en = 0; stop = 1;
      tick();
      stop = 0;
      check("err_exit", 32'(err_a), 0);
      start = 1; stop = 1;
      tick();
      start = 0; stop = 0;
      check("stopstart_idle", 32'(busy_a), 0);

      // illegal successor state
      cfg_write(0, 0, 1, 2, 'h010);
      cfg_write(12, 0, 1, 0, 'h040);
      start = 1;
      cfg_we = 1; cfg_addr = 6'h08; cfg_data = {1'b1, 4'd12, 9'h020};
      tick();
      start = 0; cfg_we = 0; en = 1; x = 2'b00;
      #1;
      check("ill_t0", 32'(t_a), 'h010);
      tick();
      check("ill_t2", 32'(t_a), 'h020);
      tick();
      check("ill_s12", 32'(state_a), 12);
      check("ill_t12", 32'(t_a), 0);
      tick();
      check("ill_err", 32'(err_a), 1);
      check("ill_hold", 32'(state_a), 12);
      start = 1;
      tick();
      start = 0;
      check("ill_start_ign", 32'(err_a), 1);
      stop = 1;
      tick();
      stop = 0;
      check("ill_stop_s", 32'(state_a), 0);
      check("ill_stop_err", 32'(err_a), 0);

      // random phase: preload the table, then random control traffic
      idle_inputs();
      for (int i = 0; i < 64; i++)
         cfg_write(i / 4, i % 4, $urandom_range(0, 9) != 0, $urandom_range(0, 11),
                   $urandom_range(0, 511));
      for (int c = 0; c < 1500; c++) begin
         res    = ($urandom_range(0, 499) == 0);
         x      = NI'($urandom_range(0, 3));
         en     = ($urandom_range(0, 9) != 0);
         start  = ($urandom_range(0, 3) == 0);
         stop   = ($urandom_range(0, 29) == 0);
         cfg_we = ($urandom_range(0, 7) == 0);
         cfg_addr = (SW+NI)'($urandom_range(0, 63));
         cfg_data = {($urandom_range(0, 9) != 0), SW'($urandom_range(0, 11)),
                     NO'($urandom_range(0, 511))};
         tick();
      end
      res = 0;
      idle_inputs();
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mealy_table_engine.md
Name: mealy_table_engine

Overview:
- Programmable, table-driven Mealy control automaton; parametrised successor of the team's hard-wired microprogram control automata (fixed state decode, fixed x/y conditions, fixed t-outputs).
- The transition/output table sits in an internal register array loaded through a config port, so one block implements any controller of up to 2^SW states, NI condition inputs and NO micro-operation outputs.
- Adds run control, illegal-state detection and a completed-cycle counter; sits between the datapath condition flags and the micro-operation strobes.

Parameters:
- SW, 4, state register width; state 0 is the initial state.
- NI, 2, number of condition inputs (x[0] ~ x, x[1] ~ y).
- NO, 9, number of micro-operation outputs t[NO-1:0].
- NS, 10, number of legal states. Any state >= NS is illegal. Requires NS <= 2^SW.
- CW, 8, width of the completed-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  reset; asynchronous, active-high.
- x  in  NI  condition inputs; sampled combinationally for the current lookup.
- start  in  1  IDLE->RUN request.
- en  in  1  step enable while in RUN.
- stop  in  1  synchronous abort to IDLE.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  SW+NI  table index = {state, x}.
- cfg_data  in  1+SW+NO  entry = {valid, next[SW-1:0], out[NO-1:0]}.
- t  out  NO  micro-operation strobes (Mealy).
- state  out  SW  current automaton state.
- busy  out  1  controller in RUN.
- done  out  1  one-cycle pulse on a completed cycle.
- err  out  1  sticky; controller in ERR.
- cfg_rej  out  1  one-cycle pulse: a write was rejected.
- cycles  out  CW  count of completed cycles; saturates at all-ones.

Behaviour:
- Table: 2^(SW+NI) entries of 1+SW+NO bits each, asynchronous read.
- On res, all valid bits clear. next/out fields need not be reset.
- Control FSM has three states: IDLE, RUN, ERR.
- Reset values: ctrl=IDLE, state=0, t=0, busy=0, done=0, err=0, cfg_rej=0, cycles=0.
- The lookup entry E = table[{state, x}].
- t is combinational:
  - t = E.out only when ctrl=RUN, en=1, stop=0, E.valid=1 and state<NS.
  - Otherwise t = 0.
  - Zero latency from x to t, matching the hard-wired automata.
- IDLE:
  - state is held at 0.
  - stop=1: remain in IDLE.
  - start=1 and stop=0: go to RUN on the next edge. The first step occurs in the following cycle.
- RUN:
  - stop=1 (has priority over everything): ctrl<=IDLE, state<=0, no step, no done.
  - en=0: everything holds and t=0.
  - en=1 with E.valid=1 and state<NS: state<=E.next.
  - If E.next==0 and state!=0: done pulses high in the next cycle, and cycles increments (saturating).
  - A self-loop 0->0 is not a completed cycle.
  - en=1 with E.valid=0 or state>=NS: ctrl<=ERR, err<=1, state holds, t=0.
  - E.next>=NS is accepted as a transition and is caught as illegal on the following step.
- ERR:
  - t=0 and err=1.
  - Exits only on stop (ctrl<=IDLE, state<=0, err<=0) or on res.
  - start is ignored in ERR.
- Config writes:
  - Accepted in IDLE or ERR: table[cfg_addr]<=cfg_data on the edge.
  - In RUN the write is dropped and cfg_rej pulses for one cycle.
  - A write in the same cycle as start (from IDLE) is accepted. The new entry is visible from the first RUN cycle.
- res asserted mid-RUN: all registers and valid bits clear immediately, without waiting for clk. t drops to 0 combinationally.
- busy = (ctrl==RUN). cycles is cleared only by res.

Test Plan:
- Reset checks:
  - Assert res mid-run -> t=0, state=0, busy=0, err=0 and cycles=0 immediately.
  - A start afterwards with no table loaded -> first en step goes to ERR (valid bits cleared).
- Two-state loop:
  - Program {0,x=01}->{1,next=1,out=0x002}, {1,x=01}->{1,next=0,out=0x100}, then start, en=1, x=01.
  - -> t=0x002, then 0x100; state toggles 0,1,0.
  - done pulses once per return to 0; cycles reaches 3 after 6 steps.
- Mealy zero latency: with state=0, change x from 01 to 00 mid-cycle with entry {0,00} valid, out=0x001 -> t changes to 0x001 in the same cycle.
- Illegal state:
  - Entry {state=2,x=00} with next=12 and NS=10 -> transition to 12 taken.
  - Next en step: err=1, t=0, state stays 12.
  - start is ignored; stop -> IDLE, state=0, err=0.
- Config and control priorities:
  - cfg_we during RUN -> cfg_rej=1 for one cycle and the table is unchanged (read back by stepping).
  - stop and start asserted together in IDLE -> stays IDLE.
  - en=0 in RUN -> state holds and t=0.
- Counter saturation: with CW=2, run 5 complete cycles -> cycles=3, done still pulses each cycle.
